sync_fifo_flags: RTL and testbench
==================================

# sync_fifo_flags

Parametrised single-clock FIFO: the next generation of the team's FIFO DUT family. It adds configurable depth, programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. It is used wherever producer and consumer share one clock, and is verified with the same UVM environment and flag-checking scoreboard approach as the asynchronous FIFO.

## Interface
- FIFO_WIDTH, 32, data word width in bits (≥1).
- FIFO_DEPTH, 16, number of entries; power of two, ≥4.
- AFULL_THRESH, FIFO_DEPTH-2, almost_full asserts when fill_count ≥ this value (1..FIFO_DEPTH).
- AEMPTY_THRESH, 2, almost_empty asserts when fill_count ≤ this value (0..FIFO_DEPTH-1).
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- clk  input  1  single clock, all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- data_in  input  FIFO_WIDTH  write data.
- w_en  input  1  write request.
- r_en  input  1  read request.
- data_out  output  FIFO_WIDTH  read data.
- data_valid  output  1  FWFT=0: one-cycle pulse marking new data_out; FWFT=1: equals !empty.
- empty, full  output  1  occupancy flags.
- almost_empty, almost_full  output  1  threshold flags.
- fill_count  output  $clog2(FIFO_DEPTH)+1  current number of entries, 0..FIFO_DEPTH.
- overflow, underflow  output  1  one-cycle error pulses.

## Operation
- Pointers wr_ptr and rd_ptr are $clog2(FIFO_DEPTH)+1 bits wide. The MSB is the wrap bit; the low bits address memory.
- Flag decode from the pointers: equal pointers means empty. Equal low bits with differing wrap bits means full.
- fill_count = wr_ptr − rd_ptr, computed modulo 2^(ptr width).
- Write accepted = w_en && (!full || read accepted this cycle). When accepted: mem[wr_ptr] ← data_in, then wr_ptr increments.
- Read accepted = r_en && !empty. Data written in the same cycle is never readable in that cycle, even when the FIFO is empty.
- w_en while full with no accepted read: write dropped, overflow pulses, state unchanged.
- r_en while empty: underflow pulses, state unchanged, data_out holds its value. In FWFT=0 no data_valid pulse is produced.
- Simultaneous accepted read and write: fill_count unchanged, both pointers advance. This holds at full and at any level except empty.
- Wrap-around: pointer low bits roll from FIFO_DEPTH-1 to 0 and the wrap bit toggles. No entries are lost or duplicated.
- FWFT=0: an accepted read at edge k loads data_out with mem[rd_ptr] at edge k, and data_valid is high for the following cycle.
- FWFT=1: data_out continuously presents mem[rd_ptr]. It is don't-care while empty. An accepted read pops the head and exposes the next entry.

## Timing
- Reset (rst_n low, asynchronous): pointers 0, fill_count 0, empty 1, almost_empty 1, full 0, almost_full 0, data_valid 0, overflow 0, underflow 0, data_out 0. Memory contents are not reset.
- Reset asserted mid-operation discards all contents immediately. The first write is accepted on the first rising edge after rst_n deasserts.
- Flags, fill_count, data_out and data_valid are registered and reflect post-edge state. They are valid the cycle after the write/read edge.
- Write-to-read latency: the first write at edge k clears empty after edge k.
  - FWFT=1: data appears on data_out after edge k.
  - FWFT=0: the earliest read edge is k+1, and data_out is valid after edge k+1.
- overflow and underflow are high for exactly the one cycle following the offending edge.

## Structure
- FIFO_pkg gains the defaults for FIFO_WIDTH, FIFO_DEPTH, AFULL_THRESH, AEMPTY_THRESH and FWFT.
- FIFO_pkg also gains a localparam-derived PTR_W = $clog2(FIFO_DEPTH)+1.
- FIFO_pkg also gains the typedef fifo_status_s packing {full, almost_full, empty, almost_empty, overflow, underflow} for monitors and the scoreboard.
- One sub-module, sync_fifo_mem: a FIFO_DEPTH×FIFO_WIDTH register array with one synchronous write port and one asynchronous read port. The top level owns the pointers, flags and output register.
- Elaboration-time assertions check that FIFO_DEPTH is a power of two and that both thresholds are in range.

## Test plan
- Reset, then 16 writes of 0x00..0x0F (depth 16): full=1, almost_full first high after write 14, fill_count=16. A 17th write pulses overflow and fill_count stays 16.
- Drain a full FIFO with 16 reads (FWFT=0): data_out sequence 0x00..0x0F, each with a data_valid pulse. empty=1 after the last read. A 17th read pulses underflow and data_out holds 0x0F.
- Fill 16, then 40 cycles of simultaneous w_en/r_en with incrementing data: output order preserved across 2+ pointer wraps, fill_count constant at 16, no overflow.
- FWFT=1: a single write of 0xA5A5A5A5 to an empty FIFO shows data_out=0xA5A5A5A5 and data_valid=1 after that edge with no read. One read returns empty=1.
- Simultaneous w_en and r_en on an empty FIFO: the write is accepted, underflow pulses, fill_count=1.
- Write 8 entries, then assert rst_n low asynchronously mid-cycle: flags return to their reset values immediately and fill_count=0. After release, the next read sees empty with no stale data.

Source files
------------

// File: rtl/FIFO_pkg.sv
// Shared defaults, derived widths and status types for the synchronous FIFO family.
package FIFO_pkg;

  localparam int FIFO_WIDTH_DEF    = 32;
  localparam int FIFO_DEPTH_DEF    = 16;
  localparam int AFULL_THRESH_DEF  = FIFO_DEPTH_DEF - 2;
  localparam int AEMPTY_THRESH_DEF = 2;
  localparam int FWFT_DEF          = 0;

  // One extra pointer bit beyond the address distinguishes full from empty.
  localparam int PTR_W = $clog2(FIFO_DEPTH_DEF) + 1;

  typedef enum logic {
    READ_REGISTERED = 1'b0,
    READ_FWFT       = 1'b1
  } read_mode_e;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_s;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one asynchronous read port.
module sync_fifo_mem #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [WIDTH-1:0]  wrData_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic [WIDTH-1:0]  rdData_o
);

  // Contents are deliberately left unreset; validity is tracked by the pointers.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, threshold flags, error pulses and selectable FWFT read mode.
module sync_fifo_flags
  import FIFO_pkg::*;
#(
  parameter int FIFO_WIDTH    = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = AEMPTY_THRESH_DEF,
  parameter int FWFT          = FWFT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [FIFO_WIDTH-1:0]       data_in,
  input  logic                        w_en,
  input  logic                        r_en,
  output logic [FIFO_WIDTH-1:0]       data_out,
  output logic                        data_valid,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic [$clog2(FIFO_DEPTH):0] fill_count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PtrW  = ptr_width(FIFO_DEPTH);
  localparam int AddrW = PtrW - 1;

  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [PtrW-1:0] AFullT  = PtrW'(AFULL_THRESH);
  localparam logic [PtrW-1:0] AEmptyT = PtrW'(AEMPTY_THRESH);

  localparam read_mode_e ReadMode = (FWFT != 0) ? READ_FWFT : READ_REGISTERED;

  if (!is_pow2(FIFO_DEPTH) || (FIFO_DEPTH < 4)) begin : gBadDepth
    $error("sync_fifo_flags: FIFO_DEPTH must be a power of two and at least 4");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > FIFO_DEPTH)) begin : gBadAFull
    $error("sync_fifo_flags: AFULL_THRESH must lie in 1..FIFO_DEPTH");
  end
  if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > FIFO_DEPTH - 1)) begin : gBadAEmpty
    $error("sync_fifo_flags: AEMPTY_THRESH must lie in 0..FIFO_DEPTH-1");
  end
  if (FIFO_WIDTH < 1) begin : gBadWidth
    $error("sync_fifo_flags: FIFO_WIDTH must be at least 1");
  end

  logic [PtrW-1:0]       wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]       rdPtr_q, rdPtr_d;
  logic [PtrW-1:0]       fillCount_q, fillCount_d;
  fifo_status_s          status_q, status_d;
  logic                  rdAccept;
  logic                  wrAccept;
  logic [FIFO_WIDTH-1:0] memRdData;

  // Reads only see entries already present before this edge; a full FIFO
  // still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    rdAccept    = r_en && !status_q.empty;
    wrAccept    = w_en && (!status_q.full || rdAccept);

    wrPtr_d     = wrAccept ? (wrPtr_q + PtrOne) : wrPtr_q;
    rdPtr_d     = rdAccept ? (rdPtr_q + PtrOne) : rdPtr_q;
    fillCount_d = wrPtr_d - rdPtr_d;

    status_d              = '0;
    status_d.empty        = (wrPtr_d == rdPtr_d);
    status_d.full         = (wrPtr_d[AddrW-1:0] == rdPtr_d[AddrW-1:0]) &&
                            (wrPtr_d[PtrW-1] != rdPtr_d[PtrW-1]);
    status_d.almost_full  = (fillCount_d >= AFullT);
    status_d.almost_empty = (fillCount_d <= AEmptyT);
    status_d.overflow     = w_en && !wrAccept;
    status_d.underflow    = r_en && status_q.empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q               <= '0;
      rdPtr_q               <= '0;
      fillCount_q           <= '0;
      status_q              <= '0;
      status_q.empty        <= 1'b1;
      status_q.almost_empty <= 1'b1;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fillCount_q <= fillCount_d;
      status_q    <= status_d;
    end
  end

  sync_fifo_mem #(
    .WIDTH  (FIFO_WIDTH),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (AddrW)
  ) uMem (
    .clk      (clk),
    .wrEn_i   (wrAccept),
    .wrAddr_i (wrPtr_q[AddrW-1:0]),
    .wrData_i (data_in),
    .rdAddr_i (rdPtr_q[AddrW-1:0]),
    .rdData_o (memRdData)
  );

  if (ReadMode == READ_REGISTERED) begin : gRegRead
    logic [FIFO_WIDTH-1:0] dataOut_q, dataOut_d;
    logic                  dataValid_q, dataValid_d;

    always_comb begin
      dataOut_d   = rdAccept ? memRdData : dataOut_q;
      dataValid_d = rdAccept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dataOut_q   <= '0;
        dataValid_q <= 1'b0;
      end else begin
        dataOut_q   <= dataOut_d;
        dataValid_q <= dataValid_d;
      end
    end

    assign data_out   = dataOut_q;
    assign data_valid = dataValid_q;
  end else begin : gFwftRead
    // Head entry is shown directly; zero while empty keeps reset output clean.
    assign data_out   = status_q.empty ? '0 : memRdData;
    assign data_valid = !status_q.empty;
  end

  assign empty        = status_q.empty;
  assign full         = status_q.full;
  assign almost_empty = status_q.almost_empty;
  assign almost_full  = status_q.almost_full;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;
  assign fill_count   = fillCount_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: one registered-read and one FWFT instance against a queue-based model.
module tb_sync_fifo_flags;

  localparam int Depth = 16;
  localparam int Width = 32;

  logic             clk;
  logic             rst_n;
  logic [Width-1:0] dataIn;
  logic             wEn;
  logic             rEn;

  logic [Width-1:0] dout0, dout1;
  logic             dv0, dv1, empty0, empty1, full0, full1;
  logic             ae0, ae1, af0, af1, ovf0, ovf1, udf0, udf1;
  logic [4:0]       fill0, fill1;

  int checkCount = 0;
  int errorCount = 0;

  logic [Width-1:0] modelQ[$];
  logic [Width-1:0] expDout0;
  logic             expDv0, expOvf, expUdf;

  typedef struct {
    logic             w;
    logic             r;
    logic [Width-1:0] d;
    int               fill;
    logic             empty;
    logic             udf;
    logic             dv;
    logic [Width-1:0] dout;
  } vec_t;

  vec_t vecs[8];

  sync_fifo_flags #(.FWFT(0)) dutReg (
    .clk(clk), .rst_n(rst_n), .data_in(dataIn), .w_en(wEn), .r_en(rEn),
    .data_out(dout0), .data_valid(dv0), .empty(empty0), .full(full0),
    .almost_empty(ae0), .almost_full(af0), .fill_count(fill0),
    .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_flags #(.FWFT(1)) dutFwft (
    .clk(clk), .rst_n(rst_n), .data_in(dataIn), .w_en(wEn), .r_en(rEn),
    .data_out(dout1), .data_valid(dv1), .empty(empty1), .full(full1),
    .almost_empty(ae1), .almost_full(af1), .fill_count(fill1),
    .overflow(ovf1), .underflow(udf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareModel();
    int n;
    n = modelQ.size();
    checkOutput("reg fill", 64'(fill0), 64'(n));
    checkOutput("reg empty", 64'(empty0), 64'(n == 0));
    checkOutput("reg full", 64'(full0), 64'(n == Depth));
    checkOutput("reg afull", 64'(af0), 64'(n >= Depth - 2));
    checkOutput("reg aempty", 64'(ae0), 64'(n <= 2));
    checkOutput("reg overflow", 64'(ovf0), 64'(expOvf));
    checkOutput("reg underflow", 64'(udf0), 64'(expUdf));
    checkOutput("reg data_valid", 64'(dv0), 64'(expDv0));
    checkOutput("reg data_out", 64'(dout0), 64'(expDout0));
    checkOutput("fwft fill", 64'(fill1), 64'(n));
    checkOutput("fwft empty", 64'(empty1), 64'(n == 0));
    checkOutput("fwft full", 64'(full1), 64'(n == Depth));
    checkOutput("fwft overflow", 64'(ovf1), 64'(expOvf));
    checkOutput("fwft underflow", 64'(udf1), 64'(expUdf));
    checkOutput("fwft data_valid", 64'(dv1), 64'(n != 0));
    if (n != 0) begin
      checkOutput("fwft data_out", 64'(dout1), 64'(modelQ[0]));
    end
  endtask

  // One clock of stimulus: the model applies the FIFO rules, then both DUTs are compared after the edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [Width-1:0] d);
    logic rdOk, wrOk;
    wEn    = w;
    rEn    = r;
    dataIn = d;
    rdOk   = r && (modelQ.size() > 0);
    wrOk   = w && ((modelQ.size() < Depth) || rdOk);
    expOvf = w && !wrOk;
    expUdf = r && (modelQ.size() == 0);
    expDv0 = rdOk;
    if (rdOk) expDout0 = modelQ.pop_front();
    if (wrOk) modelQ.push_back(d);
    @(posedge clk);
    #1;
    compareModel();
  endtask

  task automatic clearModel();
    modelQ.delete();
    expDout0 = '0;
    expDv0   = 1'b0;
    expOvf   = 1'b0;
    expUdf   = 1'b0;
  endtask

  task automatic resetDut();
    rst_n  = 1'b0;
    wEn    = 1'b0;
    rEn    = 1'b0;
    dataIn = '0;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    compareModel();
    checkOutput("reset aempty", 64'(ae0), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int wp, rp;
    rst_n  = 1'b1;
    wEn    = 1'b0;
    rEn    = 1'b0;
    dataIn = '0;
    clearModel();

    //           w     r     d          fill empty udf   dv    dout
    vecs[0] = '{1'b1, 1'b1, 32'h11, 1, 1'b0, 1'b1, 1'b0, 32'h00};
    vecs[1] = '{1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b0, 1'b1, 32'h11};
    vecs[2] = '{1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b1, 1'b0, 32'h11};
    vecs[3] = '{1'b1, 1'b0, 32'h22, 1, 1'b0, 1'b0, 1'b0, 32'h11};
    vecs[4] = '{1'b1, 1'b0, 32'h33, 2, 1'b0, 1'b0, 1'b0, 32'h11};
    vecs[5] = '{1'b1, 1'b1, 32'h44, 2, 1'b0, 1'b0, 1'b1, 32'h22};
    vecs[6] = '{1'b0, 1'b1, 32'h00, 1, 1'b0, 1'b0, 1'b1, 32'h33};
    vecs[7] = '{1'b0, 1'b0, 32'h00, 1, 1'b0, 1'b0, 1'b0, 32'h33};

    resetDut();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].w, vecs[i].r, vecs[i].d);
      checkOutput("vec fill", 64'(fill0), 64'(vecs[i].fill));
      checkOutput("vec empty", 64'(empty0), 64'(vecs[i].empty));
      checkOutput("vec underflow", 64'(udf0), 64'(vecs[i].udf));
      checkOutput("vec data_valid", 64'(dv0), 64'(vecs[i].dv));
      checkOutput("vec data_out", 64'(dout0), 64'(vecs[i].dout));
    end

    // Fill to full, watching almost_full rise after the 14th write, then overflow.
    resetDut();
    for (int i = 0; i < Depth; i++) begin
      applyStimulus(1'b1, 1'b0, Width'(i));
      checkOutput("fill afull", 64'(af0), 64'(i >= 13));
    end
    checkOutput("fill full", 64'(full0), 64'(1));
    checkOutput("fill count", 64'(fill0), 64'(16));
    applyStimulus(1'b1, 1'b0, 32'hDEAD);
    checkOutput("overflow pulse", 64'(ovf0), 64'(1));
    checkOutput("overflow count", 64'(fill0), 64'(16));

    // Drain in order, then underflow holds the last word.
    for (int i = 0; i < Depth; i++) begin
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput("drain data", 64'(dout0), 64'(i));
      checkOutput("drain valid", 64'(dv0), 64'(1));
    end
    checkOutput("drain empty", 64'(empty0), 64'(1));
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("underflow pulse", 64'(udf0), 64'(1));
    checkOutput("underflow hold", 64'(dout0), 64'(32'h0F));
    checkOutput("underflow no valid", 64'(dv0), 64'(0));

    // Full FIFO streaming through several pointer wraps.
    resetDut();
    for (int i = 0; i < Depth; i++) applyStimulus(1'b1, 1'b0, Width'(100 + i));
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b1, Width'(200 + i));
      checkOutput("stream count", 64'(fill0), 64'(16));
      checkOutput("stream overflow", 64'(ovf0), 64'(0));
      checkOutput("stream order", 64'(dout0), (i < 16) ? 64'(100 + i) : 64'(200 + i - 16));
    end

    // FWFT: the written word is visible right after the write edge.
    resetDut();
    applyStimulus(1'b1, 1'b0, 32'hA5A5A5A5);
    checkOutput("fwft show data", 64'(dout1), 64'(32'hA5A5A5A5));
    checkOutput("fwft show valid", 64'(dv1), 64'(1));
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("fwft pop empty", 64'(empty1), 64'(1));

    // Asynchronous reset in the middle of a cycle.
    resetDut();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, Width'(32'h50 + i));
    wEn = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async empty", 64'(empty0), 64'(1));
    checkOutput("async count", 64'(fill0), 64'(0));
    checkOutput("async aempty", 64'(ae0), 64'(1));
    checkOutput("async afull", 64'(af0), 64'(0));
    checkOutput("async fwft empty", 64'(empty1), 64'(1));
    clearModel();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("post reset underflow", 64'(udf0), 64'(1));
    checkOutput("post reset no valid", 64'(dv0), 64'(0));
    checkOutput("post reset data", 64'(dout0), 64'(0));

    // Randomised traffic with shifting write/read bias.
    resetDut();
    for (int phase = 0; phase < 4; phase++) begin
      wp = (phase % 2 == 0) ? 75 : 30;
      rp = (phase % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 100; i++) begin
        applyStimulus($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
